// File: rtl/mdu_divider.sv
// Iterative radix-2 non-restoring divider for RISC-V DIV/DIVU/REM/REMU.
// Optional early-out path for trivial quotients: define MDU_DIV_EARLY_OUT_EN.
module mdu_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    output logic             ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       funct3,
    input  logic             flush,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] rem,
    output logic [WIDTH-1:0] result,
    output logic             done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES_VAL = {WIDTH{1'b1}};

`ifdef MDU_DIV_EARLY_OUT_EN
    localparam logic EARLY_OUT = 1'b1;
`else
    localparam logic EARLY_OUT = 1'b0;
`endif

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   pr_q, pr_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] a_orig_q, a_orig_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             rem_sel_q, rem_sel_d;
    logic             div0_q, div0_d;
    logic             ovf_q, ovf_d;
    logic             small_q, small_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] result_q, result_d;

    // Operand decode at the accept edge; funct3[2]=0 falls back to DIVU.
    logic             signed_op, rem_op;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             in_div0, in_ovf, in_small;

    assign signed_op = funct3[2] & ~funct3[0];
    assign rem_op    = funct3[2] & funct3[1];
    assign a_mag     = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_mag     = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;
    assign in_div0   = (b == '0);
    assign in_ovf    = signed_op && (a == MIN_VAL) && (b == ONES_VAL);
    assign in_small  = (a_mag < b_mag);

    // The shifted remainder may wrap in WIDTH+1 bits; the post-add value always fits.
    logic [WIDTH:0]   pr_shift, pr_step;
    logic [WIDTH-1:0] r_mag, q_fin, r_fin;

    assign pr_shift = {pr_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign pr_step  = pr_q[WIDTH] ? (pr_shift + {1'b0, dvs_q}) : (pr_shift - {1'b0, dvs_q});
    assign r_mag    = pr_q[WIDTH] ? (pr_q[WIDTH-1:0] + dvs_q) : pr_q[WIDTH-1:0];
    assign q_fin    = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
    assign r_fin    = neg_rem_q ? (~r_mag + 1'b1) : r_mag;

    always_comb begin
        // NOTE: every next-state signal defaults to its register so no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        pr_d      = pr_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        a_orig_d  = a_orig_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        rem_sel_d = rem_sel_q;
        div0_d    = div0_q;
        ovf_d     = ovf_q;
        small_d   = small_q;
        y_d       = y_q;
        rem_d     = rem_q;
        result_d  = result_q;

        case (state_q)
            S_IDLE: begin
                if (valid && !flush) begin
                    cnt_d     = CNT_W'(WIDTH - 1);
                    pr_d      = '0;
                    quo_d     = a_mag;
                    dvs_d     = b_mag;
                    a_orig_d  = a;
                    neg_quo_d = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]) & ~in_div0;
                    neg_rem_d = signed_op & a[WIDTH-1];
                    rem_sel_d = rem_op;
                    div0_d    = in_div0;
                    ovf_d     = in_ovf;
                    small_d   = EARLY_OUT & in_small;
                    state_d   = (EARLY_OUT && (in_div0 || in_ovf || in_small)) ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    pr_d  = pr_step;
                    quo_d = {quo_q[WIDTH-2:0], ~pr_step[WIDTH]};
                    if (cnt_q == '0) state_d = S_FIX;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (div0_q) begin
                        y_d   = ONES_VAL;
                        rem_d = a_orig_q;
                    end else if (ovf_q) begin
                        y_d   = a_orig_q;
                        rem_d = '0;
                    end else if (small_q) begin
                        y_d   = '0;
                        rem_d = a_orig_q;
                    end else begin
                        y_d   = q_fin;
                        rem_d = r_fin;
                    end
                    result_d = rem_sel_q ? rem_d : y_d;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pr_q      <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            a_orig_q  <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_sel_q <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
            small_q   <= 1'b0;
            y_q       <= '0;
            rem_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pr_q      <= pr_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            a_orig_q  <= a_orig_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            rem_sel_q <= rem_sel_d;
            div0_q    <= div0_d;
            ovf_q     <= ovf_d;
            small_q   <= small_d;
            y_q       <= y_d;
            rem_q     <= rem_d;
            result_q  <= result_d;
        end
    end

    assign ready  = (state_q == S_IDLE);
    assign done   = (state_q == S_DONE);
    assign y      = y_q;
    assign rem    = rem_q;
    assign result = result_q;

endmodule

// File: tb/tb_mdu_divider.sv
// Scoreboard bench for mdu_divider: reference results from native SV division,
// latency, flush, async reset and divide-by-zero/overflow corner cases.
module tb_mdu_divider;

    localparam int WIDTH = 32;
    localparam logic [WIDTH-1:0] MIN_V  = 32'h8000_0000;
    localparam logic [WIDTH-1:0] ONES_V = 32'hFFFF_FFFF;
    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    logic             clk = 1'b0;
    logic             reset;
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] a, b;
    logic [2:0]       funct3;
    logic             flush;
    logic [WIDTH-1:0] y, rem, result;
    logic             done;

    mdu_divider #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .valid  (valid),
        .ready  (ready),
        .a      (a),
        .b      (b),
        .funct3 (funct3),
        .flush  (flush),
        .y      (y),
        .rem    (rem),
        .result (result),
        .done   (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] rem;
        logic [WIDTH-1:0] result;
        int               lat;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                                   input logic [2:0] f3);
        exp_t        e;
        logic        sgn;
        longint      sa, sb;
        logic [WIDTH-1:0] am, bm;
        sgn = f3[2] & ~f3[0];
        if (op_b == '0) begin
            e.y = ONES_V;
            e.rem = op_a;
        end else if (sgn && op_a == MIN_V && op_b == ONES_V) begin
            e.y = MIN_V;
            e.rem = '0;
        end else if (sgn) begin
            sa = longint'($signed(op_a));
            sb = longint'($signed(op_b));
            e.y = WIDTH'(sa / sb);
            e.rem = WIDTH'(sa % sb);
        end else begin
            e.y = op_a / op_b;
            e.rem = op_a % op_b;
        end
        e.result = (f3[2] & f3[1]) ? e.rem : e.y;
        am = (sgn && op_a[WIDTH-1]) ? -op_a : op_a;
        bm = (sgn && op_b[WIDTH-1]) ? -op_b : op_b;
        e.lat = WIDTH + 2;
`ifdef MDU_DIV_EARLY_OUT_EN
        if (op_b == '0 || (sgn && op_a == MIN_V && op_b == ONES_V) || am < bm) e.lat = 2;
`else
        if (am == bm && am != am) e.lat = 0;
`endif
        return e;
    endfunction

    // Latency counts edges from the accept edge to the edge that captures done=1.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] op_a,
                          input logic [WIDTH-1:0] op_b, input logic [2:0] f3);
        int   k;
        bit   got_done;
        bit   busy_ready;
        exp_t e;
        @(negedge clk);
        valid = 1'b1; a = op_a; b = op_b; funct3 = f3;
        k = 0;
        while (!ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_ready_in"}, 64'(ready), 64'd1);
        @(posedge clk);
        sb_q.push_back(model(op_a, op_b, f3));
        @(negedge clk);
        valid = 1'b0; a = $urandom; b = $urandom; funct3 = 3'($urandom);
        k = 0; got_done = 1'b0; busy_ready = 1'b0;
        while (k < WIDTH + 10) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (ready) busy_ready = 1'b1;
            @(negedge clk);
            k++;
        end
        check({tag, "_done"}, 64'(got_done), 64'd1);
        e = sb_q.pop_front();
        if (got_done) begin
            check({tag, "_y"}, 64'(y), 64'(e.y));
            check({tag, "_rem"}, 64'(rem), 64'(e.rem));
            check({tag, "_result"}, 64'(result), 64'(e.result));
            check({tag, "_lat"}, 64'(k + 1), 64'(e.lat));
            check({tag, "_busy_ready"}, 64'(busy_ready), 64'd0);
            check({tag, "_ready_at_done"}, 64'(ready), 64'd0);
            last_exp = e;
            @(negedge clk);
            check({tag, "_pulse"}, 64'(done), 64'd0);
        end
    endtask

    initial begin
        int   k;
        bit   saw;
        logic [WIDTH-1:0] ra, rb;
        reset = 1'b1; valid = 1'b0; flush = 1'b0; a = '0; b = '0; funct3 = '0;
        last_exp = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_y", 64'(y), 64'd0);
        check("rst_rem", 64'(rem), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        reset = 1'b0;

        run_op("div_m7_2", 32'hFFFF_FFF9, 32'd2, F_DIV);
        run_op("remu_ff_2", 32'hFFFF_FFFF, 32'd2, F_REMU);
        run_op("divu_100_7", 32'd100, 32'd7, F_DIVU);
        run_op("div_5_0", 32'd5, 32'd0, F_DIV);
        run_op("rem_min_0", MIN_V, 32'd0, F_REM);
        run_op("div_ovf", MIN_V, ONES_V, F_DIV);
        run_op("rem_ovf", MIN_V, ONES_V, F_REM);
        run_op("rem_m7_3", 32'hFFFF_FFF9, 32'd3, F_REM);
        run_op("div_small", 32'd3, 32'hFFFF_FFF9, F_DIV);
        run_op("f3_000", 32'hFFFF_FFF9, 32'd2, 3'b000);
        run_op("divu_0_0", 32'd0, 32'd0, F_DIVU);
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? WIDTH'($urandom_range(1, 300)) : $urandom;
            run_op($sformatf("rand%0d", i), ra, rb, 3'b100 | 3'(i % 4));
        end

        // Flush in IDLE alongside valid: the request must not be taken.
        @(negedge clk);
        valid = 1'b1; flush = 1'b1; a = 32'd9; b = 32'd3; funct3 = F_DIV;
        @(negedge clk);
        valid = 1'b0; flush = 1'b0;
        check("idle_flush_ready", 64'(ready), 64'd1);

        // Flush mid-CALC of DIV 1000/3.
        valid = 1'b1; a = 32'd1000; b = 32'd3; funct3 = F_DIV;
        @(negedge clk);
        valid = 1'b0;
        check("flush_busy", 64'(ready), 64'd0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_ready", 64'(ready), 64'd1);
        saw = 1'b0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            if (done) saw = 1'b1;
            @(negedge clk);
        end
        check("flush_no_done", 64'(saw), 64'd0);
        check("flush_y_hold", 64'(y), 64'(last_exp.y));
        check("flush_rem_hold", 64'(rem), 64'(last_exp.rem));
        run_op("divu_after_flush", 32'd1000, 32'd3, F_DIVU);

        // Async reset between edges while in CALC.
        @(negedge clk);
        valid = 1'b1; a = 32'd12345; b = 32'd7; funct3 = F_DIVU;
        @(negedge clk);
        valid = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_ready", 64'(ready), 64'd1);
        check("arst_done", 64'(done), 64'd0);
        check("arst_y", 64'(y), 64'd0);
        check("arst_rem", 64'(rem), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("div_after_rst", 32'd12345, 32'd7, F_DIV);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
